// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Optional perf counters in pipeline_ctrl are enabled by PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard compare: the load in EX feeds a source register of the instruction in ID.
// Purely combinational; x0 never creates a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       mem_read_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       load_use_o
);

    assign load_use_o = mem_read_i && (rd_i != REG_X0) &&
                        ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for a 5-stage pipeline: stalls, flushes, bubbles and a memory watchdog.
// Optional Stall_cnt_o/Flush_cnt_o perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_Rd_i,
    input  logic [4:0]  IFID_Rs1_i,
    input  logic [4:0]  IFID_Rs2_i,
    input  logic        Branch_taken_i,
    input  logic        Mem_req_i,
    input  logic        Mem_ack_i,
    output logic        PCWrite_o,
    output logic        IFID_Write_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Bubble_o,
    output logic        EXMEM_Write_o,
    output logic        MEMWB_Write_o,
    output logic        MEMWB_Bubble_o,
    output logic        Mem_err_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] Stall_cnt_o,
    output logic [31:0] Flush_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             load_use;

    hazard_detect u_hazard (
        .mem_read_i (IDEX_MemRead_i),
        .rd_i       (IDEX_Rd_i),
        .rs1_i      (IFID_Rs1_i),
        .rs2_i      (IFID_Rs2_i),
        .load_use_o (load_use)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        PCWrite_o      = 1'b1;
        IFID_Write_o   = 1'b1;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b0;
        EXMEM_Write_o  = 1'b1;
        MEMWB_Write_o  = 1'b1;
        MEMWB_Bubble_o = 1'b0;

        case (state_q)
            RUN: begin
                if (Mem_req_i && !Mem_ack_i) begin
                    // Freeze upstream; MEM/WB keeps clocking but only carries a bubble.
                    PCWrite_o      = 1'b0;
                    IFID_Write_o   = 1'b0;
                    EXMEM_Write_o  = 1'b0;
                    MEMWB_Bubble_o = 1'b1;
                    state_d        = MEM_WAIT;
                    wait_cnt_d     = CNT_W'(1);
                end else if (load_use) begin
                    // A taken branch this cycle is re-resolved once the load data is forwarded.
                    PCWrite_o     = 1'b0;
                    IFID_Write_o  = 1'b0;
                    IDEX_Bubble_o = 1'b1;
                end else if (Branch_taken_i) begin
                    IFID_Flush_o = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (Mem_ack_i) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    PCWrite_o      = 1'b0;
                    IFID_Write_o   = 1'b0;
                    EXMEM_Write_o  = 1'b0;
                    MEMWB_Bubble_o = 1'b1;
                    if (wait_cnt_q == CNT_LAST) begin
                        state_d    = ERR;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                PCWrite_o      = 1'b0;
                IFID_Write_o   = 1'b0;
                EXMEM_Write_o  = 1'b0;
                MEMWB_Write_o  = 1'b0;
                MEMWB_Bubble_o = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (rst_i) begin
            PCWrite_o      = 1'b0;
            IFID_Write_o   = 1'b0;
            IFID_Flush_o   = 1'b1;
            IDEX_Bubble_o  = 1'b1;
            EXMEM_Write_o  = 1'b0;
            MEMWB_Write_o  = 1'b0;
            MEMWB_Bubble_o = 1'b1;
        end
    end

    assign Mem_err_o = (state_q == ERR);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PCWrite_o)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (IFID_Flush_o)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign Stall_cnt_o = stall_cnt_q;
    assign Flush_cnt_o = flush_cnt_q;
`endif

endmodule
